// File: rtl/fp32_max_reduce.sv
// fp32_max_reduce
//   Streaming IEEE-754 single-precision max reduction. After a start pulse, the
//   unit consumes `len` elements over a valid/ready stream, one element per cycle.
//   It then presents the maximum value and the index of its first occurrence.
//   Any NaN in the vector yields a canonical qNaN together with the index of the
//   first NaN.
// Ports
//   clk, rst_n             rising-edge clock, asynchronous active-low reset
//   start, len             begin a new vector of `len` elements (honoured in IDLE)
//   in_valid/in_ready      element stream handshake, in_data carries the FP32 word
//   out_valid/out_ready    result handshake, out_max/out_idx carry the result
//   busy                   high whenever the unit is not idle
module fp32_max_reduce #(
    parameter int unsigned LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_max,
    output logic [LEN_W-1:0] out_idx,
    output logic             busy
);

    localparam logic [31:0] NEG_INF = 32'hFF80_0000;
    localparam logic [31:0] QNAN    = 32'h7FC0_0000;

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

    state_t             state_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   cnt_q;
    logic [31:0]        max_q;
    logic [LEN_W-1:0]   idx_q;
    logic               nan_q;
    logic [LEN_W-1:0]   nan_idx_q;
    logic [31:0]        out_max_q;
    logic [LEN_W-1:0]   out_idx_q;

    logic               in_nan;
    logic               both_zero;
    logic               gt;
    logic               last;
    logic [31:0]        max_d;
    logic [LEN_W-1:0]   idx_d;
    logic               nan_d;
    logic [LEN_W-1:0]   nan_idx_d;

    assign in_nan    = (&in_data[30:23]) && (|in_data[22:0]);
    assign both_zero = (in_data[30:0] == 31'd0) && (max_q[30:0] == 31'd0);
    assign last      = (cnt_q == len_q - LEN_W'(1));

    // Sign-magnitude ordering: the running max never holds a NaN, so a plain
    // magnitude compare is sufficient once the signs are known.
    always_comb begin
        gt = 1'b0;
        if (in_data[31] != max_q[31]) begin
            gt = !in_data[31] && !both_zero;
        end else if (!in_data[31]) begin
            gt = in_data[30:0] > max_q[30:0];
        end else begin
            gt = in_data[30:0] < max_q[30:0];
        end
    end

    // Running state after accepting in_data. Once a NaN is seen, nothing changes.
    always_comb begin
        max_d     = max_q;
        idx_d     = idx_q;
        nan_d     = nan_q;
        nan_idx_d = nan_idx_q;
        if (!nan_q) begin
            if (in_nan) begin
                nan_d     = 1'b1;
                nan_idx_d = cnt_q;
            end else if (gt) begin
                max_d = in_data;
                idx_d = cnt_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            len_q     <= '0;
            cnt_q     <= '0;
            max_q     <= '0;
            idx_q     <= '0;
            nan_q     <= 1'b0;
            nan_idx_q <= '0;
            out_max_q <= '0;
            out_idx_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        len_q     <= len;
                        cnt_q     <= '0;
                        max_q     <= NEG_INF;
                        idx_q     <= '0;
                        nan_q     <= 1'b0;
                        nan_idx_q <= '0;
                        if (len == '0) begin
                            out_max_q <= NEG_INF;
                            out_idx_q <= '0;
                            state_q   <= S_DONE;
                        end else begin
                            state_q   <= S_ACCUM;
                        end
                    end
                end
                S_ACCUM: begin
                    if (in_valid) begin
                        cnt_q     <= cnt_q + LEN_W'(1);
                        max_q     <= max_d;
                        idx_q     <= idx_d;
                        nan_q     <= nan_d;
                        nan_idx_q <= nan_idx_d;
                        // The result is committed on the same edge as the last element.
                        if (last) begin
                            out_max_q <= nan_d ? QNAN : max_d;
                            out_idx_q <= nan_d ? nan_idx_d : idx_d;
                            state_q   <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == S_ACCUM);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign out_max   = out_max_q;
    assign out_idx   = out_idx_q;

endmodule

// File: tb/tb_fp32_max_reduce.sv
// Testbench for fp32_max_reduce: random and directed vectors checked against a
// real-valued reference model, with backpressure, ignored starts and reset abort.
module tb_fp32_max_reduce;

    localparam int unsigned LEN_W = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_data;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_max;
    logic [LEN_W-1:0] out_idx;
    logic             busy;

    fp32_max_reduce #(.LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_max   (out_max),
        .out_idx   (out_idx),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic check_reset_outputs(input string tag);
        check32({tag, "_in_ready"},  32'(in_ready),  32'd0);
        check32({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check32({tag, "_out_max"},   out_max,        32'h0);
        check32({tag, "_out_idx"},   32'(out_idx),   32'd0);
        check32({tag, "_busy"},      32'(busy),      32'd0);
    endtask

    typedef struct {
        logic [31:0]      mx;
        logic [LEN_W-1:0] ix;
        int               n;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] vec[256];

    // Reference model: decode to a real number and pick the first maximum.
    function automatic real fval(input logic [31:0] x);
        int  e;
        real mag;
        e = int'(x[30:23]);
        if (e == 255) mag = 1.0e300;
        else if (e == 0) mag = real'(x[22:0]) * (2.0 ** (-149));
        else mag = (real'(x[22:0]) + 8388608.0) * (2.0 ** (e - 150));
        return x[31] ? -mag : mag;
    endfunction

    function automatic bit is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    function automatic void model(input int n, output logic [31:0] mx, output logic [LEN_W-1:0] ix);
        int best;
        mx = 32'hFF80_0000;
        ix = '0;
        for (int i = 0; i < n; i++) begin
            if (is_nan(vec[i])) begin
                mx = 32'h7FC0_0000;
                ix = LEN_W'(i);
                return;
            end
        end
        if (n == 0) return;
        best = 0;
        for (int i = 1; i < n; i++)
            if (fval(vec[i]) > fval(vec[best])) best = i;
        mx = vec[best];
        ix = LEN_W'(best);
    endfunction

    function automatic logic [31:0] rnd_fp();
        int unsigned r;
        logic        s;
        r = $urandom_range(0, 15);
        s = 1'($urandom % 2);
        case (r)
            0:       return {s, 31'd0};
            1:       return {s, 8'hFF, 23'd0};
            2:       return ($urandom % 3 == 0) ? {s, 8'hFF, 23'($urandom_range(1, 100))} : {s, 31'd0};
            3, 4:    return {s, 8'h00, 23'($urandom_range(1, 4))};
            default: return {s, 8'(125 + $urandom_range(0, 3)), 23'($urandom_range(0, 3))};
        endcase
    endfunction

    // Compare process: result values, latency, idle after handshake, reset values.
    initial begin
        int unsigned xfer;
        bit          due;
        bit          hs;
        xfer = 0;
        due  = 1'b0;
        hs   = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check_reset_outputs("rst");
                exp_q.delete();
                xfer = 0;
                due  = 1'b0;
                hs   = 1'b0;
            end else begin
                if (due) check32("latency_out_valid", 32'(out_valid), 32'd1);
                due = 1'b0;
                if (hs) check32("idle_after_handshake", 32'(busy), 32'd0);
                hs = 1'b0;
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        check32("spurious_out_valid", 32'(out_valid), 32'd0);
                    end else begin
                        check32("out_max", out_max, exp_q[0].mx);
                        check32("out_idx", 32'(out_idx), 32'(exp_q[0].ix));
                        if (out_ready) begin
                            void'(exp_q.pop_front());
                            xfer = 0;
                            hs   = 1'b1;
                        end
                    end
                end
                if (in_valid && in_ready) begin
                    xfer++;
                    if (exp_q.size() > 0 && xfer == exp_q[0].n) due = 1'b1;
                end
            end
        end
    end

    // Runs one vector from IDLE; called at posedge+1.
    task automatic run_vec(input int n, input bit rand_valid, input bit rand_ready, input bit start_in_done);
        exp_t e;
        int   k;
        int   guard;
        bit   xf;
        bit   done;
        model(n, e.mx, e.ix);
        e.n = n;
        exp_q.push_back(e);
        start = 1'b1;
        len   = LEN_W'(n);
        @(posedge clk); #1;
        start = 1'b0;
        len   = LEN_W'($urandom);
        if (n == 0) begin
            @(negedge clk);
            check32("len0_out_valid", 32'(out_valid), 32'd1);
            @(posedge clk); #1;
        end
        k = 0;
        guard = 0;
        while (k < n && guard < 4000) begin
            in_valid = rand_valid ? 1'($urandom % 2) : 1'b1;
            in_data  = vec[k];
            @(negedge clk);
            xf = in_valid && in_ready;
            @(posedge clk); #1;
            if (xf) k++;
            guard++;
        end
        in_valid = 1'b0;
        in_data  = $urandom;
        if (k != n) check32("input_timeout", 32'(k), 32'(n));
        guard = 0;
        done  = 1'b0;
        while (!done && guard < 4000) begin
            out_ready = (rand_ready && guard < 5) ? 1'b0 :
                        (rand_ready ? 1'($urandom % 2) : 1'b1);
            start     = start_in_done ? 1'($urandom % 2) : 1'b0;
            len       = LEN_W'(2);
            @(negedge clk);
            done = out_valid && out_ready;
            @(posedge clk); #1;
            guard++;
        end
        start     = 1'b0;
        out_ready = 1'b0;
        if (!done) check32("result_timeout", 32'(done), 32'd1);
    endtask

    task automatic directed(input string name, input int n, input logic [31:0] mx, input logic [LEN_W-1:0] ix);
        logic [31:0]      m_mx;
        logic [LEN_W-1:0] m_ix;
        model(n, m_mx, m_ix);
        check32({name, "_model_max"}, m_mx, mx);
        check32({name, "_model_idx"}, 32'(m_ix), 32'(ix));
        run_vec(n, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        int n;
        rst_n     = 1'b0;
        start     = 1'b0;
        len       = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        vec[0] = 32'h3F80_0000; vec[1] = 32'hC000_0000; vec[2] = 32'h4040_0000; vec[3] = 32'h4000_0000;
        directed("T1", 4, 32'h4040_0000, 2);
        vec[0] = 32'h8000_0000; vec[1] = 32'h0000_0000; vec[2] = 32'hBF80_0000;
        directed("T2", 3, 32'h8000_0000, 0);
        vec[0] = 32'hC120_0000; vec[1] = 32'hC0A0_0000; vec[2] = 32'h7FC0_0001; vec[3] = 32'h7F80_0000;
        directed("T3", 4, 32'h7FC0_0000, 2);
        directed("T4a", 0, 32'hFF80_0000, 0);
        vec[0] = 32'h0000_0001; vec[1] = 32'h0000_0003;
        directed("T4b", 2, 32'h0000_0003, 1);
        vec[0] = 32'hFF80_0000; vec[1] = 32'hFF80_0000;
        directed("neg_inf_first", 2, 32'hFF80_0000, 0);

        // Backpressure, stalls and starts during DONE / at the handshake.
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < 3; i++) vec[i] = rnd_fp();
            run_vec(3, 1'b1, 1'b1, 1'b1);
        end

        // Random vectors.
        for (int t = 0; t < 40; t++) begin
            n = $urandom_range(0, 12);
            for (int i = 0; i < n; i++) vec[i] = rnd_fp();
            run_vec(n, 1'($urandom % 2), 1'($urandom % 2), 1'($urandom % 2));
        end

        // Maximum length: count must not wrap.
        for (int i = 0; i < 255; i++) vec[i] = {1'b0, 8'd120, 23'(i % 97)};
        vec[254] = 32'h7F80_0000;
        run_vec(255, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 255; i++) vec[i] = {1'b1, 8'd130, 23'(i % 50)};
        run_vec(255, 1'b1, 1'b0, 1'b0);

        // Reset in mid-vector aborts the vector.
        vec[0] = 32'h4000_0000; vec[1] = 32'h4100_0000;
        start = 1'b1;
        len   = LEN_W'(5);
        @(posedge clk); #1;
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = vec[0];
        @(posedge clk); #1;
        in_data  = vec[1];
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check_reset_outputs("T6_abort");
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        vec[0] = 32'h3F80_0000;
        directed("T6", 1, 32'h3F80_0000, 0);

        repeat (3) @(posedge clk);
        #1;
        check32("final_idle", 32'(busy), 32'd0);
        check32("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
